// File: rtl/ay_bus_sequencer.sv
`timescale 1ns/1ps
// ay_bus_sequencer
// Shares the TurboSound AY control bus (bdir/bc1/data) between the Z80 port
// decoder and a secondary register-write requester. In IDLE the CPU levels
// pass straight through and latch/chip-select cycles are snooped into shadow
// state. A requester write runs as an atomic sequence: select chip, latch
// register, write data, then restore the CPU's chip and latched register.
// While the sequence runs, the CPU is held off with WAIT.
//
// Optional feature macro: AYSEQ_SKIP_REDUNDANT_EN
//   defined   : SEL and RSEL are skipped when the requested chip equals the
//               shadow chip at accept time.
//   undefined : chip-select phases are always issued unless disable_turboay=1.
//
// Parameters:
//   PHASE_CYC        cycles each bus phase is driven (1..15), plus 1 gap cycle
// Ports:
//   clk              system clock
//   reset            asynchronous active-high reset
//   disable_turboay  second AY absent; no chip-select phases issued
//   cpu_bdir/cpu_bc1 CPU-side AY control levels
//   cpu_din[7:0]     CPU-side AY data
//   wait_n           Z80 WAIT, active low
//   req_valid        requester write pending
//   req_ready        request accepted when req_valid & req_ready
//   req_chip         1 = first AY, 0 = second AY
//   req_reg[3:0]     AY register number
//   req_data[7:0]    value to write
//   req_err          one-cycle pulse: request dropped
//   busy             sequence in progress
//   bdir/bc1/dout    to turbosound
//
// States:
//   IDLE   | CPU pass-through, snooping, accepts requests
//   SEL    | drive chip select for the captured chip
//   LATCH  | latch captured register number
//   WRITE  | write captured data
//   RSEL   | restore CPU's chip select (shadow_chip)
//   RLATCH | restore CPU's latched register (shadow_addr)

module ay_bus_sequencer #(
    parameter int unsigned PHASE_CYC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       disable_turboay,
    input  logic       cpu_bdir,
    input  logic       cpu_bc1,
    input  logic [7:0] cpu_din,
    output logic       wait_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_chip,
    input  logic [3:0] req_reg,
    input  logic [7:0] req_data,
    output logic       req_err,
    output logic       busy,
    output logic       bdir,
    output logic       bc1,
    output logic [7:0] dout
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_LATCH,
        ST_WRITE,
        ST_RSEL,
        ST_RLATCH
    } state_t;

    localparam logic [3:0] GAP_CNT = 4'(PHASE_CYC);

    state_t     state, state_nx;
    logic [3:0] cnt;
    logic       shadow_chip;
    logic [7:0] shadow_addr;
    logic       cap_chip;
    logic [3:0] cap_reg;
    logic [7:0] cap_data;
    logic       skip_sel;
    logic       req_err_q;

    logic       accept;
    logic       drop;
    logic       skip_now;
    logic       gap;
    logic       drv_bdir;
    logic       drv_bc1;
    logic [7:0] drv_dout;

    assign req_err = req_err_q;

    always_comb begin
        req_ready = (state == ST_IDLE) & ~cpu_bdir & ~cpu_bc1 & ~reset;
        accept    = req_valid & req_ready;
        drop      = accept & disable_turboay & ~req_chip;
`ifdef AYSEQ_SKIP_REDUNDANT_EN
        skip_now  = disable_turboay | (req_chip == shadow_chip);
`else
        skip_now  = disable_turboay;
`endif
        // Last cycle of every phase is the idle gap.
        gap       = (cnt == GAP_CNT);

        state_nx  = state;
        drv_bdir  = 1'b0;
        drv_bc1   = 1'b0;
        drv_dout  = 8'h00;

        unique case (state)
            ST_IDLE: begin
                if (accept && !drop)
                    state_nx = skip_now ? ST_LATCH : ST_SEL;
            end
            ST_SEL: begin
                drv_bdir = 1'b1;
                drv_bc1  = 1'b1;
                drv_dout = {7'h7F, cap_chip};
                if (gap) state_nx = ST_LATCH;
            end
            ST_LATCH: begin
                drv_bdir = 1'b1;
                drv_bc1  = 1'b1;
                drv_dout = {4'h0, cap_reg};
                if (gap) state_nx = ST_WRITE;
            end
            ST_WRITE: begin
                drv_bdir = 1'b1;
                drv_bc1  = 1'b0;
                drv_dout = cap_data;
                if (gap) state_nx = skip_sel ? ST_RLATCH : ST_RSEL;
            end
            ST_RSEL: begin
                drv_bdir = 1'b1;
                drv_bc1  = 1'b1;
                drv_dout = {7'h7F, shadow_chip};
                if (gap) state_nx = ST_RLATCH;
            end
            ST_RLATCH: begin
                drv_bdir = 1'b1;
                drv_bc1  = 1'b1;
                drv_dout = shadow_addr;
                if (gap) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase

        if (state == ST_IDLE) begin
            bdir   = cpu_bdir;
            bc1    = cpu_bc1;
            dout   = cpu_din;
            busy   = 1'b0;
            wait_n = 1'b1;
        end else begin
            // dout stays on the phase value through the gap.
            bdir   = drv_bdir & ~gap;
            bc1    = drv_bc1 & ~gap;
            dout   = drv_dout;
            busy   = 1'b1;
            wait_n = ~(cpu_bdir | cpu_bc1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= 4'h0;
            shadow_chip <= 1'b1;
            shadow_addr <= 8'h00;
            cap_chip    <= 1'b0;
            cap_reg     <= 4'h0;
            cap_data    <= 8'h00;
            skip_sel    <= 1'b0;
            req_err_q   <= 1'b0;
        end else begin
            state     <= state_nx;
            req_err_q <= drop;

            if (state_nx != state)
                cnt <= 4'h0;
            else if (state != ST_IDLE)
                cnt <= cnt + 4'd1;

            if (state == ST_IDLE && cpu_bdir && cpu_bc1) begin
                if (cpu_din[7:1] == 7'h7F && !disable_turboay)
                    shadow_chip <= cpu_din[0];
                else
                    shadow_addr <= cpu_din;
            end

            if (accept) begin
                cap_chip <= req_chip;
                cap_reg  <= req_reg;
                cap_data <= req_data;
                skip_sel <= skip_now;
            end
        end
    end

endmodule

// File: doc/ay_bus_sequencer.md
Name: ay_bus_sequencer

Overview:
- Shares the TurboSound AY control bus (bdir/bc1/data) between the Z80 port decoder and a secondary register-write requester, e.g. a hardware music player or a ZXUNO config register.
- Sits between the CPU I/O decode and the turbosound block.
- In idle, CPU signals pass straight through and are snooped into shadow state.
- A requester write runs as an atomic bus sequence: select chip, latch register, write data, then restore the CPU's chip and register. The CPU is held off with WAIT during the sequence.

Parameters:
- PHASE_CYC, 2, clock cycles each bus phase is driven (1..15); every phase is followed by 1 idle cycle.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- disable_turboay  in  1  second AY absent; no chip-select phases issued
- cpu_bdir  in  1  CPU-side AY bdir level
- cpu_bc1  in  1  CPU-side AY bc1 level
- cpu_din  in  8  CPU-side AY data
- wait_n  out  1  Z80 WAIT, active low
- req_valid  in  1  requester write pending
- req_ready  out  1  requester accepted when req_valid & req_ready
- req_chip  in  1  1 = first AY, 0 = second AY
- req_reg  in  4  AY register number
- req_data  in  8  value to write
- req_err  out  1  one-cycle pulse: request dropped
- busy  out  1  sequence in progress
- bdir  out  1  to turbosound
- bc1  out  1  to turbosound
- dout  out  8  to turbosound din

Behaviour:
- States: IDLE, SEL, LATCH, WRITE, RSEL, RLATCH.
- Each non-IDLE state has a drive sub-phase of PHASE_CYC cycles, then a gap of 1 cycle with bdir=bc1=0 and dout held.
- Sub-phase counter is 4 bits, wrapping to 0 at each state change.

IDLE:
- bdir=cpu_bdir, bc1=cpu_bc1, dout=cpu_din (combinational pass-through); busy=0; wait_n=1.
- Snoop when cpu_bdir&cpu_bc1:
  - cpu_din[7:1]==7'h7F and disable_turboay=0: shadow_chip <= cpu_din[0].
  - Otherwise: shadow_addr <= cpu_din.
- req_ready = (state==IDLE) & ~cpu_bdir & ~cpu_bc1 & ~reset (combinational).
- Accept (req_valid&req_ready): capture req_chip/req_reg/req_data.
  - If disable_turboay=1 and req_chip=0: drop the request, pulse req_err next cycle, stay IDLE.
  - Else if disable_turboay=1: go to LATCH.
  - Else: go to SEL.

Drive values:
- SEL: bdir=1, bc1=1, dout={7'h7F, cap_chip}.
- LATCH: bdir=1, bc1=1, dout={4'h0, cap_reg}.
- WRITE: bdir=1, bc1=0, dout=cap_data.
- RSEL: bdir=1, bc1=1, dout={7'h7F, shadow_chip}; skipped when disable_turboay=1.
- RLATCH: bdir=1, bc1=1, dout=shadow_addr; after its gap, return to IDLE.

Non-IDLE rules:
- busy=1.
- wait_n = ~(cpu_bdir|cpu_bc1), combinational; the CPU holds its levels while waiting.
- No snooping; CPU inputs are ignored for the bus.

Timing:
- Full sequence with PHASE_CYC=2 is 5×3 = 15 cycles.
- req_ready reasserts on the first IDLE cycle with the CPU bus idle; back-to-back requests are allowed.

Boundary cases:
- CPU access on the accept cycle is impossible by construction (ready requires an idle CPU).
- CPU access on the first sequence cycle gets wait_n=0 immediately.
- The shadow is unchanged by requester sequences.

Reset:
- Any state goes to IDLE immediately. Sequence aborted; no restore.
- shadow_chip=1, shadow_addr=8'h00, capture registers 0, req_err=0, busy=0, counter 0.
- While in reset, outputs follow IDLE pass-through; wait_n=1, req_ready=0.

Optional Feature:
- Macro: AYSEQ_SKIP_REDUNDANT_EN.
- Defined: SEL and RSEL are skipped when cap_chip==shadow_chip at accept; a same-chip sequence is 3 phases (9 cycles at PHASE_CYC=2).
- Undefined: chip-select phases are always issued (unless disable_turboay=1); sequence length is fixed at 15 cycles.

Test Plan:
1. Reset, then CPU latch 8'h07 and write 8'h38 in IDLE -> bdir/bc1/dout mirror the CPU each cycle; shadow_addr=8'h07; wait_n=1 throughout.
2. CPU latch 8'hFE, CPU latch 8'h08, then request chip=1 reg=4'hA data=8'h55, PHASE_CYC=2, macro undefined -> exactly 15 cycles:
   - 7F|1 latch, 0A latch, 55 write, 7F|0 latch, 08 latch;
   - each phase 2 driven + 1 gap; busy=1 for 15 cycles, then back to pass-through.
3. Request accepted, CPU raises cpu_bdir=1, cpu_bc1=0 at cycle 3 of the sequence -> wait_n=0 until the sequence ends; the CPU write reaches the bus only on the first IDLE cycle.
4. disable_turboay=1:
   - req_chip=0 -> req_err pulses once; no bus activity.
   - req_chip=1 reg=3 data=8'hFF -> LATCH, WRITE, RLATCH only (9 cycles).
5. Assert reset at cycle 5 of a sequence -> same cycle: busy=0, wait_n=1, pass-through active; shadow_chip=1, shadow_addr=0.
6. Macro defined, shadow_chip=1, request chip=1 -> 9-cycle sequence with no 7F|x latches; request chip=0 -> full 15 cycles.
